decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port if_valid  input  1  fetch presents an instruction.
REQ-004 SHALL have port if_instr  input  16  instruction word; opcode in [15:11].
REQ-005 SHALL have port if_ready  output  1  decode accepts if_instr this cycle.
REQ-006 SHALL have port flush  input  1  branch redirect; kill the in-flight instruction.
REQ-007 SHALL have ports wb_en input 1, wb_reg input 3, wb_data input 16  register write-back.
REQ-008 SHALL have ports ALUSrc output 1, ALUOp output 4, ReadData1 output 16, ReadData2 output 16, extOutput output 16  registered execute operands.
REQ-009 SHALL have ports ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt (each output 1) and ex_rd (output 3)  registered ID/EX control.
REQ-010 SHALL have port err  output  1  sticky illegal-opcode flag.

Function
REQ-011 SHALL accept an instruction on a rising edge where if_valid=1 and if_ready=1; its ID/EX outputs SHALL be valid after that edge (1-cycle latency).
REQ-012 SHALL decode these opcodes, with ALUOp codes per REQ-026:
  - ADDI 01000 -> ADD.
  - SUBI 01001 -> SUB.
  - XORI 01010 -> XOR.
  - ANDNI 01011 -> ANDN.
  - ST 10000 -> ADD, memwrite.
  - LD 10001 -> ADD, memread, regwrite.
  - LBI 11000 -> PASSB.
  - R-type 11011, func [1:0] 00/01/10/11 -> ADD/SUB/XOR/ANDN.
  - SEQ 11100, SLT 11110, SLE 11111.
  - NOP 00001, HALT 00000.
REQ-013 I-type fields: Rs=[10:8], Rd=[7:5], imm5=[4:0]. R-type fields: Rs=[10:8], Rt=[7:5], Rd=[4:2]. LBI fields: Rd=[10:8], imm8=[7:0].
REQ-014 extOutput SHALL be:
  - imm5 sign-extended for ADDI, SUBI, LD, ST.
  - imm5 zero-extended for XORI, ANDNI.
  - imm8 sign-extended for LBI.
  - 0 otherwise.
REQ-015 ALUSrc SHALL be 1 for every I-type and for LBI, and 0 for R-type.
REQ-016 ReadData1 SHALL be RF[Rs] and ReadData2 SHALL be RF[Rt]; for ST, ReadData2 SHALL be RF[Rd] (store data).
REQ-017 Register reads SHALL bypass: when wb_en=1 and wb_reg equals the read index in the same cycle, the read SHALL return wb_data.
REQ-018 Load-use stall:
  - Condition: ex_valid=1, ex_memread=1, and ex_rd equals a source register actually used by the current instruction.
  - Response: if_ready=0 and a bubble enters ID/EX (ex_valid=0, all write/mem enables 0) for exactly one cycle.
REQ-019 flush=1 SHALL force a bubble into ID/EX on the next edge and SHALL hold if_ready=1 so the presented instruction is consumed and discarded; flush SHALL override a stall.
REQ-020 An unlisted opcode SHALL issue as a bubble and set err=1 until reset.
REQ-021 FSM states:
  - RUN: normal operation.
  - HALTED: entered on the edge that issues HALT; ex_halt=1 for that issued slot only; thereafter if_ready=0, ex_valid=0, and the block is exited only by rst.
REQ-022 A bubble (if_valid=0) SHALL leave ex_valid=0 and every operand output at 0.
REQ-023 Register file write SHALL occur on the rising edge when wb_en=1; a write to R0 is legal (no hardwired zero).

Reset
REQ-024 While rst=1, SHALL drive:
  - all ID/EX outputs to 0;
  - err=0, if_ready=0;
  - FSM=RUN;
  - all 8 registers to 0.
REQ-025 After rst deasserts, if_ready SHALL be 1 from the first clock edge; a reset asserted mid-stall or mid-flush SHALL discard that pending work.

Structure
REQ-026 A shared package SHALL hold:
  - the 5-bit opcode constants;
  - the 4-bit ALUOp constants: ADD=0, SUB=1, XOR=2, OR=3, AND=4, ROL=5, SLL=6, ROR=7, SRL=8, SLT=9, SLE=10, SEQ=11, SCO=12, ANDN=13, PASSB=14, BTR=15;
  - the FSM state type.
REQ-027 The register file SHALL be one sub-module, regfile_bypass: 8x16, two read ports, one write port, bypass per REQ-017.

Verification
REQ-028 Reset then ADDI R1,R0,#-3 -> next cycle ALUOp=0, ALUSrc=1, extOutput=0xFFFD, ex_rd=1, ex_regwrite=1.
REQ-029 XORI imm5=0x1F -> extOutput=0x001F; LBI imm8=0x80 -> extOutput=0xFF80, ALUOp=14.
REQ-030 LD R2 followed by ADD using Rs=R2 -> exactly one bubble cycle (if_ready=0, ex_valid=0), then ADD issues.
REQ-031 wb_en=1, wb_reg=3, wb_data=0xBEEF in the same cycle as an SLT reading R3 -> ReadData1=0xBEEF, ALUOp=9.
REQ-032 flush asserted while a SUBI is presented -> ex_valid=0 next cycle, if_ready=1, instruction not reissued.
REQ-033 HALT then further valid instructions -> ex_halt=1 for one cycle, then if_ready=0 indefinitely; opcode 00010 -> err=1 sticky.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared constants and types for the decode/issue stage.
//   - 5-bit opcode constants (opcode lives in instr[15:11])
//   - 4-bit ALUOp constants consumed by the execute stage
//   - FSM state type and state constants
//   - ID/EX pipeline register layout and immediate-extension helpers
package decode_issue_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_RTYPE = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11110;
  localparam logic [4:0] OP_SLE   = 5'b11111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_XOR   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_ROL   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_ROR   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;
  localparam logic [3:0] ALU_SLE   = 4'd10;
  localparam logic [3:0] ALU_SEQ   = 4'd11;
  localparam logic [3:0] ALU_SCO   = 4'd12;
  localparam logic [3:0] ALU_ANDN  = 4'd13;
  localparam logic [3:0] ALU_PASSB = 4'd14;
  localparam logic [3:0] ALU_BTR   = 4'd15;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN    = 1'b0;
  localparam state_t ST_HALTED = 1'b1;

  // ID/EX register contents; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        halt;
    logic [2:0]  rd;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] ext;
  } idex_t;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] zext5(input logic [4:0] v);
    return {11'd0, v};
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// regfile_bypass: 8 x 16-bit register file, two combinational read ports,
// one synchronous write port. A read of the register being written in the
// same cycle returns the write data (write-before-read bypass).
// R0 is an ordinary register.
//   clk, rst        : clock, asynchronous active-high reset (clears all regs)
//   raddr1/rdata1   : read port 1
//   raddr2/rdata2   : read port 2
//   wen/waddr/wdata : write port
module regfile_bypass (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  raddr1,
  output logic [15:0] rdata1,
  input  logic [2:0]  raddr2,
  output logic [15:0] rdata2,
  input  logic        wen,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata
);

  logic [15:0] mem [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'd0;
    end else if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (wen && (waddr == raddr1)) ? wdata : mem[raddr1];
  assign rdata2 = (wen && (waddr == raddr2)) ? wdata : mem[raddr2];

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode stage with register read, load-use stall, flush and
// halt handling, feeding a registered ID/EX stage (1-cycle latency).
//   clk, rst                  : clock, asynchronous active-high reset
//   if_valid, if_instr        : instruction from fetch (opcode in [15:11])
//   if_ready                  : decode accepts if_instr this cycle
//   flush                     : branch redirect, presented instruction is killed
//   wb_en, wb_reg, wb_data    : register write-back port
//   ALUSrc, ALUOp, ReadData1, ReadData2, extOutput : registered operands
//   ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt, ex_rd : ID/EX control
//   err                       : sticky illegal-opcode flag
//   dbg_state                 : current FSM state (RUN/HALTED)
//
// Handshake: an instruction transfers on a rising edge where if_valid=1 and
// if_ready=1. if_ready depends combinationally on if_instr (stall check) and
// flush; fetch must hold if_instr stable while if_valid=1 and if_ready=0.
// With flush=1 the transfer still happens but the instruction is discarded.
module decode_issue
  import decode_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic        ALUSrc,
  output logic [3:0]  ALUOp,
  output logic [15:0] ReadData1,
  output logic [15:0] ReadData2,
  output logic [15:0] extOutput,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_halt,
  output logic [2:0]  ex_rd,
  output logic        err,
  output state_t      dbg_state
);

  state_t      state;
  idex_t       idex;
  idex_t       dec;
  logic        legal;
  logic        uses_rs;
  logic        uses_rt;
  logic        stall;
  logic        accept;
  logic [4:0]  op;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [15:0] rdata1;
  logic [15:0] rdata2;

  assign op = if_instr[15:11];
  assign rs = if_instr[10:8];
  // [7:5] is Rt for R-format and the store-data register for ST, so one read
  // port index serves both.
  assign rt = if_instr[7:5];

  regfile_bypass u_rf (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .rdata1 (rdata1),
    .raddr2 (rt),
    .rdata2 (rdata2),
    .wen    (wb_en),
    .waddr  (wb_reg),
    .wdata  (wb_data)
  );

  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI: begin
        dec.regwrite = 1'b1;
        dec.rd       = if_instr[7:5];
        dec.alusrc   = 1'b1;
        uses_rs      = 1'b1;
        case (op)
          OP_ADDI: begin dec.aluop = ALU_ADD;  dec.ext = sext5(if_instr[4:0]); end
          OP_SUBI: begin dec.aluop = ALU_SUB;  dec.ext = sext5(if_instr[4:0]); end
          OP_XORI: begin dec.aluop = ALU_XOR;  dec.ext = zext5(if_instr[4:0]); end
          default: begin dec.aluop = ALU_ANDN; dec.ext = zext5(if_instr[4:0]); end
        endcase
      end
      OP_ST: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_ADD;
        dec.ext      = sext5(if_instr[4:0]);
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_LD: begin
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
        dec.rd       = if_instr[7:5];
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_ADD;
        dec.ext      = sext5(if_instr[4:0]);
        uses_rs      = 1'b1;
      end
      OP_LBI: begin
        dec.regwrite = 1'b1;
        dec.rd       = if_instr[10:8];
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_PASSB;
        dec.ext      = sext8(if_instr[7:0]);
      end
      OP_RTYPE, OP_SEQ, OP_SLT, OP_SLE: begin
        dec.regwrite = 1'b1;
        dec.rd       = if_instr[4:2];
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
        case (op)
          OP_SEQ: dec.aluop = ALU_SEQ;
          OP_SLT: dec.aluop = ALU_SLT;
          OP_SLE: dec.aluop = ALU_SLE;
          default: begin
            case (if_instr[1:0])
              2'b00:   dec.aluop = ALU_ADD;
              2'b01:   dec.aluop = ALU_SUB;
              2'b10:   dec.aluop = ALU_XOR;
              default: dec.aluop = ALU_ANDN;
            endcase
          end
        endcase
      end
      OP_NOP: ;
      OP_HALT: dec.halt = 1'b1;
      default: legal = 1'b0;
    endcase
    // Operands are always the raw reads of [10:8] and [7:5]; execute ignores
    // the ones an opcode does not need.
    dec.valid = 1'b1;
    dec.rd1   = rdata1;
    dec.rd2   = rdata2;
  end

  // Load-use hazard: the load in ID/EX writes a register this instruction reads.
  assign stall = if_valid && idex.valid && idex.memread &&
                 ((uses_rs && (idex.rd == rs)) || (uses_rt && (idex.rd == rt)));

  // flush overrides the stall so the killed instruction is consumed.
  assign if_ready = !rst && (state == ST_RUN) && (flush || !stall);
  assign accept   = if_valid && if_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex  <= '0;
      state <= ST_RUN;
      err   <= 1'b0;
    end else begin
      idex <= '0;
      if (accept) begin
        if (legal) idex <= dec;
        else       err  <= 1'b1;
        if (legal && dec.halt) state <= ST_HALTED;
      end
    end
  end

  assign ex_valid    = idex.valid;
  assign ex_regwrite = idex.regwrite;
  assign ex_memread  = idex.memread;
  assign ex_memwrite = idex.memwrite;
  assign ex_halt     = idex.halt;
  assign ex_rd       = idex.rd;
  assign ALUSrc      = idex.alusrc;
  assign ALUOp       = idex.aluop;
  assign ReadData1   = idex.rd1;
  assign ReadData2   = idex.rd2;
  assign extOutput   = idex.ext;
  assign dbg_state   = state;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: self-checking bench for decode_issue with a behavioural
// reference model (register array, halted/err flags, last issued slot).
module tb_decode_issue;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        hl;
    logic [2:0]  rd;
    logic        src;
    logic [3:0]  aop;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ext;
  } tb_idex_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_ready;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        ALUSrc;
  logic [3:0]  ALUOp;
  logic [15:0] ReadData1, ReadData2, extOutput;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt;
  logic [2:0]  ex_rd;
  logic        err;
  logic [0:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] m_regs [8];
  logic        m_halted;
  logic        m_err;
  tb_idex_t    m_idex;
  logic        exp_ready;
  logic        obs_ready;
  logic [60:0] exp_q [$];
  tb_idex_t    dut_vec;

  assign dut_vec = {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt,
                    ex_rd, ALUSrc, ALUOp, ReadData1, ReadData2, extOutput};

  decode_issue dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .if_ready(if_ready), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .extOutput(extOutput), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_halt(ex_halt), .ex_rd(ex_rd), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_idex   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'd0; flush = 1'b0;
    wb_en = 1'b0; wb_reg = 3'd0; wb_data = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  // ---------------- reference model ----------------
  // Registers read by an instruction, straight from the instruction-set rules.
  function automatic logic uses_reg(input logic [15:0] ins, input logic [2:0] r);
    case (ins[15:11])
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10001: return ins[10:8] == r;
      5'b10000, 5'b11011, 5'b11100, 5'b11110, 5'b11111:
        return (ins[10:8] == r) || (ins[7:5] == r);
      default: return 1'b0;
    endcase
  endfunction

  function automatic void ref_decode(input logic [15:0] ins, input logic [15:0] a,
                                     input logic [15:0] b, output logic legal,
                                     output tb_idex_t v);
    logic [3:0] func_alu [4];
    func_alu = '{4'd0, 4'd1, 4'd2, 4'd13};
    v = '0;
    legal = 1'b1;
    v.valid = 1'b1; v.a = a; v.b = b;
    case (ins[15:11])
      5'b01000: begin v.rw = 1; v.src = 1; v.rd = ins[7:5]; v.aop = 0;  v.ext = 16'($signed(ins[4:0])); end
      5'b01001: begin v.rw = 1; v.src = 1; v.rd = ins[7:5]; v.aop = 1;  v.ext = 16'($signed(ins[4:0])); end
      5'b01010: begin v.rw = 1; v.src = 1; v.rd = ins[7:5]; v.aop = 2;  v.ext = 16'(ins[4:0]); end
      5'b01011: begin v.rw = 1; v.src = 1; v.rd = ins[7:5]; v.aop = 13; v.ext = 16'(ins[4:0]); end
      5'b10000: begin v.mw = 1; v.src = 1; v.aop = 0; v.ext = 16'($signed(ins[4:0])); end
      5'b10001: begin v.mr = 1; v.rw = 1; v.src = 1; v.rd = ins[7:5]; v.aop = 0; v.ext = 16'($signed(ins[4:0])); end
      5'b11000: begin v.rw = 1; v.src = 1; v.rd = ins[10:8]; v.aop = 14; v.ext = 16'($signed(ins[7:0])); end
      5'b11011: begin v.rw = 1; v.rd = ins[4:2]; v.aop = func_alu[ins[1:0]]; end
      5'b11100: begin v.rw = 1; v.rd = ins[4:2]; v.aop = 11; end
      5'b11110: begin v.rw = 1; v.rd = ins[4:2]; v.aop = 9; end
      5'b11111: begin v.rw = 1; v.rd = ins[4:2]; v.aop = 10; end
      5'b00001: ;
      5'b00000: v.hl = 1;
      default: begin legal = 1'b0; v = '0; end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one cycle of inputs, records observed/expected if_ready, advances
  // the model across the edge and returns #1 after it.
  task automatic drive(input logic v, input logic [15:0] ins, input logic fl,
                       input logic we, input logic [2:0] wr, input logic [15:0] wd);
    tb_idex_t    nxt;
    logic        lg;
    logic [15:0] a, b;
    if_valid = v; if_instr = ins; flush = fl;
    wb_en = we; wb_reg = wr; wb_data = wd;
    #1;
    obs_ready = if_ready;
    exp_ready = !m_halted &&
                (fl || !(v && m_idex.valid && m_idex.mr && uses_reg(ins, m_idex.rd)));
    nxt = '0;
    if (v && exp_ready && !fl) begin
      a = (we && wr == ins[10:8]) ? wd : m_regs[ins[10:8]];
      b = (we && wr == ins[7:5])  ? wd : m_regs[ins[7:5]];
      ref_decode(ins, a, b, lg, nxt);
      if (!lg) m_err = 1'b1;
      else if (ins[15:11] == 5'b00000) m_halted = 1'b1;
    end
    if (we) m_regs[wr] = wd;
    m_idex = nxt;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // load something, then reset in the middle of a load-use stall
    drive(1'b1, 16'b10001_000_010_00000, 1'b0, 1'b1, 3'd5, 16'h1234);
    if_valid = 1'b1; if_instr = 16'b11011_010_011_001_00;
    #1;
    total_cnt++;
    if (if_ready !== 1'b0) $display("FAIL reset_prestall if_ready=%0b want 0", if_ready);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (dut_vec !== 61'd0) $display("FAIL reset_outputs got=%h want 0", dut_vec);
    else pass_cnt++;
    total_cnt++;
    if (if_ready !== 1'b0 || err !== 1'b0 || dbg_state !== 1'b0)
      $display("FAIL reset_ctrl if_ready=%0b err=%0b state=%0b want 0/0/0", if_ready, err, dbg_state);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (if_ready !== 1'b1) $display("FAIL reset_release if_ready=%0b want 1", if_ready);
    else pass_cnt++;
    // stall discarded: the ADD issues at once and R5 reads back as 0
    drive(1'b1, 16'b11011_101_010_001_00, 1'b0, 1'b0, 3'd0, 16'd0);
    total_cnt++;
    if (obs_ready !== 1'b1 || dut_vec !== m_idex || ReadData1 !== 16'd0)
      $display("FAIL reset_after_stall ready=%0b got=%h want=%h", obs_ready, dut_vec, m_idex);
    else pass_cnt++;
  endtask

  task automatic test_immediates();
    drive(1'b1, 16'b01000_000_001_11101, 1'b0, 1'b0, 3'd0, 16'd0);  // ADDI R1,R0,#-3
    total_cnt++;
    if (ALUOp !== 4'd0 || ALUSrc !== 1'b1 || extOutput !== 16'hFFFD ||
        ex_rd !== 3'd1 || ex_regwrite !== 1'b1 || ex_valid !== 1'b1)
      $display("FAIL addi aluop=%0d src=%0b ext=%h rd=%0d rw=%0b want 0/1/fffd/1/1",
               ALUOp, ALUSrc, extOutput, ex_rd, ex_regwrite);
    else pass_cnt++;
    drive(1'b1, 16'b01010_000_000_11111, 1'b0, 1'b0, 3'd0, 16'd0);  // XORI imm 0x1F
    total_cnt++;
    if (extOutput !== 16'h001F || ALUOp !== 4'd2)
      $display("FAIL xori ext=%h aluop=%0d want 001f/2", extOutput, ALUOp);
    else pass_cnt++;
    drive(1'b1, 16'b11000_001_10000000, 1'b0, 1'b0, 3'd0, 16'd0);   // LBI R1,#0x80
    total_cnt++;
    if (extOutput !== 16'hFF80 || ALUOp !== 4'd14 || ex_rd !== 3'd1)
      $display("FAIL lbi ext=%h aluop=%0d rd=%0d want ff80/14/1", extOutput, ALUOp, ex_rd);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    drive(1'b1, 16'b10001_000_010_00000, 1'b0, 1'b0, 3'd0, 16'd0);  // LD R2
    drive(1'b1, 16'b11011_010_011_001_00, 1'b0, 1'b0, 3'd0, 16'd0); // ADD R1,R2,R3
    total_cnt++;
    if (obs_ready !== 1'b0 || ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0)
      $display("FAIL load_use_bubble ready=%0b valid=%0b want 0/0", obs_ready, ex_valid);
    else pass_cnt++;
    drive(1'b1, 16'b11011_010_011_001_00, 1'b0, 1'b0, 3'd0, 16'd0);
    total_cnt++;
    if (obs_ready !== 1'b1 || ex_valid !== 1'b1 || ALUOp !== 4'd0 || ex_rd !== 3'd1)
      $display("FAIL load_use_issue ready=%0b valid=%0b aluop=%0d rd=%0d want 1/1/0/1",
               obs_ready, ex_valid, ALUOp, ex_rd);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    drive(1'b1, 16'b11110_011_000_001_00, 1'b0, 1'b1, 3'd3, 16'hBEEF); // SLT R1,R3,R0
    total_cnt++;
    if (ReadData1 !== 16'hBEEF || ALUOp !== 4'd9 || ALUSrc !== 1'b0)
      $display("FAIL bypass rd1=%h aluop=%0d want beef/9", ReadData1, ALUOp);
    else pass_cnt++;
    drive(1'b1, 16'b10000_000_011_00001, 1'b0, 1'b0, 3'd0, 16'd0);     // ST R3 -> data
    total_cnt++;
    if (ReadData2 !== 16'hBEEF || ex_memwrite !== 1'b1 || ex_regwrite !== 1'b0)
      $display("FAIL store_data rd2=%h mw=%0b want beef/1", ReadData2, ex_memwrite);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1'b1, 16'b10001_000_100_00000, 1'b0, 1'b0, 3'd0, 16'd0);  // LD R4
    drive(1'b1, 16'b01001_100_101_00010, 1'b1, 1'b0, 3'd0, 16'd0);  // SUBI uses R4 + flush
    total_cnt++;
    if (obs_ready !== 1'b1 || ex_valid !== 1'b0)
      $display("FAIL flush ready=%0b valid=%0b want 1/0", obs_ready, ex_valid);
    else pass_cnt++;
    idle();
    total_cnt++;
    if (ex_valid !== 1'b0) $display("FAIL flush_no_reissue valid=%0b want 0", ex_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [4:0]  ops [13];
    logic [15:0] ins;
    tb_idex_t    got;
    int          bad;
    ops = '{5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10000, 5'b10001, 5'b10001,
            5'b11000, 5'b11011, 5'b11100, 5'b11110, 5'b11111, 5'b00001};
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      ins = {ops[$urandom_range(0, 12)], 11'($urandom)};
      // narrow register indices so load-use hazards are frequent
      ins[10] = 1'b0; ins[7] = 1'b0;
      drive($urandom_range(0, 9) != 0, ins, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
      exp_q.push_back(m_idex);
      got = dut_vec;
      total_cnt++;
      if (got !== tb_idex_t'(exp_q.pop_front()) || obs_ready !== exp_ready || err !== m_err) begin
        if (bad < 8)
          $display("FAIL random[%0d] instr=%h got=%h ready=%0b want=%h ready=%0b",
                   i, ins, got, obs_ready, m_idex, exp_ready);
        bad++;
      end else pass_cnt++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    drive(1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 16'd0);
    total_cnt++;
    if (ex_halt !== 1'b1 || ex_valid !== 1'b1 || dbg_state !== 1'b1)
      $display("FAIL halt_issue halt=%0b valid=%0b state=%0b want 1/1/1", ex_halt, ex_valid, dbg_state);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'b01000_000_001_00001, 1'b0, 1'b0, 3'd0, 16'd0);
      total_cnt++;
      if (obs_ready !== 1'b0 || ex_valid !== 1'b0 || ex_halt !== 1'b0)
        $display("FAIL halted[%0d] ready=%0b valid=%0b halt=%0b want 0/0/0",
                 i, obs_ready, ex_valid, ex_halt);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 16'b00010_000_000_00000, 1'b0, 1'b0, 3'd0, 16'd0);
    total_cnt++;
    if (err !== 1'b1 || ex_valid !== 1'b0)
      $display("FAIL illegal err=%0b valid=%0b want 1/0", err, ex_valid);
    else pass_cnt++;
    drive(1'b1, 16'b01000_000_001_00001, 1'b0, 1'b0, 3'd0, 16'd0);
    idle();
    total_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky err=%0b want 1", err);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (err !== 1'b0) $display("FAIL err_reset err=%0b want 0", err);
    else pass_cnt++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_immediates();
    test_load_use();
    test_bypass();
    test_flush();
    test_random();
    test_halt();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
